pong_ctrl: RTL
==============

PONG_CTRL -- requirements
Module: pong_ctrl

Interface
REQ-001 Parameter TIMER_TICKS, default 120, frame ticks held in NEWBALL/OVER (2 s at 60 Hz).
REQ-002 Parameter INIT_BALLS, default 3, ball reserve loaded at new game (range 1..3).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 tick  in  1  one-cycle pulse per video frame.
REQ-006 btn  in  2  debounced player buttons, level.
REQ-007 hit  in  1  one-cycle pulse: ball struck paddle.
REQ-008 miss  in  1  one-cycle pulse: ball left playfield.
REQ-009 ball  out  2  balls remaining in reserve, feeds text overlay.
REQ-010 dig1, dig0  out  4 each  BCD score tens/units, feeds text overlay.
REQ-011 text_en  out  4  region enables [3]=score [2]=logo [1]=rule [0]=over.
REQ-012 gra_still  out  1  high = playfield graphics frozen, ball parked.

Function
REQ-013 FSM states NEWGAME, PLAY, NEWBALL, OVER; Moore outputs decoded from state register, so outputs change one cycle after the triggering edge.
REQ-014 NEWGAME: any btn bit high -> PLAY, ball <= INIT_BALLS-1.
REQ-015 PLAY: miss with ball==0 -> OVER, timer <= TIMER_TICKS.
REQ-016 PLAY: miss with ball!=0 -> NEWBALL, ball <= ball-1, timer <= TIMER_TICKS.
REQ-017 NEWBALL: timer==0 and any btn bit high -> PLAY; btn ignored while timer!=0.
REQ-018 OVER: timer==0 -> NEWGAME, ball <= INIT_BALLS, score <= 00.
REQ-019 Timer width ceil(log2(TIMER_TICKS+1)); decrements by 1 per tick while nonzero; holds at 0; load overrides tick in same cycle.
REQ-020 hit in PLAY increments score as 2-digit BCD; 09->10, 99->00 (wrap).
REQ-021 hit and miss in same PLAY cycle: score increments AND miss transition taken.
REQ-022 hit and miss outside PLAY ignored; ball never decrements below 0.
REQ-023 text_en: NEWGAME 4'b1110, PLAY 4'b1000, NEWBALL 4'b1000, OVER 4'b1001.
REQ-024 gra_still = 0 in PLAY only, 1 in all other states.
REQ-025 btn held through OVER->NEWGAME starts PLAY on next cycle (no edge detection required).

Reset
REQ-026 reset_n low at a clk edge: state NEWGAME, ball=INIT_BALLS, dig1=dig0=0, timer=0; text_en=4'b1110, gra_still=1 from first cycle after.
REQ-027 Reset mid-game (any state, any timer value) aborts immediately to REQ-026 values; reset dominates hit, miss, btn, tick.

Structure
REQ-028 Shared package pong_pkg holds state enum, text_en bit-index constants, and INIT_BALLS/TIMER_TICKS defaults for use by pong_text and top level.
REQ-029 One sub-module, score_bcd: 2-digit BCD counter with clear and inc, synchronous active-low reset.
REQ-030 Target 150-250 lines RTL; no combinational path from inputs to outputs.

Verification
REQ-031 Reset then btn=2'b01 one cycle -> PLAY, ball=2, text_en=4'b1000, gra_still=0.
REQ-032 In PLAY, 12 hit pulses -> dig1=1, dig0=2; from score 99 one hit -> 00.
REQ-033 In PLAY ball=2, miss -> NEWBALL, ball=1; btn held throughout: stays NEWBALL for 120 ticks, PLAY on cycle after timer reaches 0.
REQ-034 In PLAY ball=0, miss -> OVER, text_en=4'b1001; after 120 ticks -> NEWGAME, ball=3, score 00.
REQ-035 Simultaneous hit+miss at score 05, ball=1 -> score 06, NEWBALL, ball=0.
REQ-036 reset_n low during NEWBALL with timer=50 -> next cycle NEWGAME, timer=0, score 00, ball=3.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller and its text overlay.
package pong_pkg;

  // Game flow states
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  // Bit positions inside text_en
  localparam int TXT_SCORE = 3;
  localparam int TXT_LOGO  = 2;
  localparam int TXT_RULE  = 1;
  localparam int TXT_OVER  = 0;

  // Default game parameters: 2 s of frames at 60 Hz, three balls per game
  localparam int TIMER_TICKS_DEF = 120;
  localparam int INIT_BALLS_DEF  = 3;

  // Which overlay regions are shown in each state
  function automatic logic [3:0] text_en_of(input state_e s);
    logic [3:0] t;
    t = '0;
    t[TXT_SCORE] = 1'b1;
    case (s)
      ST_NEWGAME: begin
        t[TXT_LOGO] = 1'b1;
        t[TXT_RULE] = 1'b1;
      end
      ST_OVER:    t[TXT_OVER] = 1'b1;
      default:    ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pong_ctrl_if.sv
// Game-event inputs and overlay/graphics outputs of the pong controller.
interface pong_ctrl_if;
  logic       tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic [1:0] ball;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] text_en;
  logic       gra_still;

  // Side that produces game events and consumes status
  modport master (
    output tick, btn, hit, miss,
    input  ball, dig1, dig0, text_en, gra_still
  );

  // The controller itself
  modport slave (
    input  tick, btn, hit, miss,
    output ball, dig1, dig0, text_en, gra_still
  );
endinterface

// File: rtl/pong_ctrl_score_bcd.sv
// Two-digit BCD score counter: clear to 00, or increment with 99 wrapping to 00.
module score_bcd (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;

  // Next score: clear wins over increment; units carry into tens at 9
  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    if (clr) begin
      dig1_d = 4'd0;
      dig0_d = 4'd0;
    end else if (inc) begin
      if (dig0_q == 4'd9) begin
        dig0_d = 4'd0;
        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  // Score registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else begin
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
    end
  end

  assign dig1 = dig1_q;
  assign dig0 = dig0_q;

endmodule

// File: rtl/pong_ctrl.sv
// Pong game controller: game flow FSM, ball reserve, frame timer and score.
// All outputs come straight from registers or from a decode of the state
// register, so there is no combinational path from inputs to outputs.
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int TIMER_TICKS = TIMER_TICKS_DEF,
  parameter int INIT_BALLS  = INIT_BALLS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  pong_ctrl_if.slave  bus
);

  localparam int              TW         = $clog2(TIMER_TICKS + 1);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(TIMER_TICKS);
  localparam logic [1:0]      BALLS_FULL = 2'(INIT_BALLS);
  localparam logic [1:0]      BALLS_PLAY = 2'(INIT_BALLS - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    ball_q,  ball_d;
  logic          score_clr;
  logic          score_inc;
  logic          any_btn;

  assign any_btn = |bus.btn;

  // Next state, ball reserve, timer and score controls
  always_comb begin
    state_d   = state_q;
    ball_d    = ball_q;
    timer_d   = timer_q;
    score_clr = 1'b0;
    score_inc = 1'b0;

    // Frame countdown; any load below overrides this
    if (bus.tick && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end

    case (state_q)
      ST_NEWGAME: begin
        if (any_btn) begin
          state_d = ST_PLAY;
          ball_d  = BALLS_PLAY;
        end
      end
      ST_PLAY: begin
        // A hit and a miss in the same cycle both take effect
        score_inc = bus.hit;
        if (bus.miss) begin
          timer_d = TIMER_LOAD;
          if (ball_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_NEWBALL;
            ball_d  = ball_q - 2'd1;
          end
        end
      end
      ST_NEWBALL: begin
        if ((timer_q == '0) && any_btn) begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (timer_q == '0) begin
          state_d   = ST_NEWGAME;
          ball_d    = BALLS_FULL;
          score_clr = 1'b1;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  // State, ball and timer registers; reset overrides every input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_NEWGAME;
      ball_q  <= BALLS_FULL;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ball_q  <= ball_d;
      timer_q <= timer_d;
    end
  end

  score_bcd u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (score_clr),
    .inc     (score_inc),
    .dig1    (bus.dig1),
    .dig0    (bus.dig0)
  );

  assign bus.ball      = ball_q;
  assign bus.text_en   = text_en_of(state_q);
  assign bus.gra_still = (state_q != ST_PLAY);

endmodule
